// File: rtl/dual_req_rr_arbiter_if.sv
// Request/data/handshake bundle between two requesters, the arbiter and one downstream sink.
// The arbiter connects through the slave modport; sources and sink drive through master.
interface dual_req_rr_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              req_a;
    logic [DATA_W-1:0] din_a;
    logic              req_b;
    logic [DATA_W-1:0] din_b;
    logic              gnt_a;
    logic              gnt_b;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;

    modport slave (
        input  req_a, din_a, req_b, din_b, dout_ready,
        output gnt_a, gnt_b, dout, dout_valid
    );

    modport master (
        output req_a, din_a, req_b, din_b, dout_ready,
        input  gnt_a, gnt_b, dout, dout_valid
    );
endinterface

// File: rtl/dual_req_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output slot between requesters A and B,
// with bursts bounded by HOLD_MAX under contention. Define ARB_BEAT_CNT_EN for saturating beat counters.
module dual_req_rr_arbiter #(
    parameter int DATA_W   = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    dual_req_rr_arbiter_if.slave bus
`ifdef ARB_BEAT_CNT_EN
    ,
    output logic [15:0]          beats_a,
    output logic [15:0]          beats_b
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    state_t            state_q, state_d;
    logic              last_b_q, last_b_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              gnt_a_q, gnt_b_q;

    logic              load_en;
    logic              own_req;
    logic              oth_req;
    logic [DATA_W-1:0] own_din;
    state_t            oth_state;
    logic              accept;
    logic [7:0]        cnt_inc;
    logic              hold_hit;

    // View the inputs from the current owner's side so both OWN states share one path.
    always_comb begin
        own_req   = 1'b0;
        oth_req   = 1'b0;
        own_din   = '0;
        oth_state = IDLE;
        case (state_q)
            OWN_A: begin
                own_req   = bus.req_a;
                oth_req   = bus.req_b;
                own_din   = bus.din_a;
                oth_state = OWN_B;
            end
            OWN_B: begin
                own_req   = bus.req_b;
                oth_req   = bus.req_a;
                own_din   = bus.din_b;
                oth_state = OWN_A;
            end
            default: begin
                own_req   = 1'b0;
            end
        endcase
    end

    assign load_en  = !valid_q || bus.dout_ready;
    assign accept   = own_req && load_en;
    assign cnt_inc  = cnt_q + 8'd1;
    assign hold_hit = accept && (cnt_inc == HOLD_LIM);

    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        valid_d  = valid_q;

        if (accept) begin
            dout_d  = own_din;
            valid_d = 1'b1;
            cnt_d   = cnt_inc;
        end else if (valid_q && bus.dout_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.req_a && (!bus.req_b || last_b_q)) begin
                    state_d = OWN_A;
                    cnt_d   = '0;
                end else if (bus.req_b) begin
                    state_d = OWN_B;
                    cnt_d   = '0;
                end
            end
            OWN_A, OWN_B: begin
                if (!own_req) begin
                    state_d  = oth_req ? oth_state : IDLE;
                    last_b_d = (state_q == OWN_B);
                    cnt_d    = '0;
                end else if (hold_hit) begin
                    // Burst limit only forces a hand-over when someone is actually waiting.
                    cnt_d = '0;
                    if (oth_req) begin
                        state_d  = oth_state;
                        last_b_d = (state_q == OWN_B);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_b_q <= 1'b1;
            cnt_q    <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            gnt_a_q  <= (state_d == OWN_A);
            gnt_b_q  <= (state_d == OWN_B);
        end
    end

    assign bus.gnt_a      = gnt_a_q;
    assign bus.gnt_b      = gnt_b_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;

`ifdef ARB_BEAT_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] beats_a_q, beats_b_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            beats_a_q <= '0;
            beats_b_q <= '0;
        end else begin
            if (accept && (state_q == OWN_A)) begin
                beats_a_q <= sat_inc16(beats_a_q);
            end
            if (accept && (state_q == OWN_B)) begin
                beats_b_q <= sat_inc16(beats_b_q);
            end
        end
    end

    assign beats_a = beats_a_q;
    assign beats_b = beats_b_q;
`endif

endmodule

// File: tb/tb_dual_req_rr_arbiter.sv
// Scoreboard bench for dual_req_rr_arbiter: a per-cycle reference model predicts grants and
// accepted beats; a monitor compares grants/valid each cycle and pops expected data on handshakes.
module tb_dual_req_rr_arbiter;
    localparam int DATA_W   = 8;
    localparam int HOLD_MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dual_req_rr_arbiter_if #(.DATA_W(DATA_W)) bus ();

`ifdef ARB_BEAT_CNT_EN
    logic [15:0] beats_a;
    logic [15:0] beats_b;
`endif

    dual_req_rr_arbiter #(.DATA_W(DATA_W), .HOLD_MAX(HOLD_MAX)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ARB_BEAT_CNT_EN
        ,
        .beats_a(beats_a),
        .beats_b(beats_b)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Reference model: owner 0 = nobody, 1 = A, 2 = B; run = beats in the current tenure.
    int         m_owner = 0;
    int         m_last  = 2;
    int         m_run   = 0;
    bit         m_valid = 1'b0;
    int         m_ba    = 0;
    int         m_bb    = 0;
    logic [7:0] exp_q[$];
    bit         hs_src[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic model_step();
        bit ra, rb, rdy, mine, other, acc;
        ra  = bus.req_a;
        rb  = bus.req_b;
        rdy = bus.dout_ready;
        if (rst) begin
            m_owner = 0; m_last = 2; m_run = 0; m_valid = 1'b0;
            m_ba = 0; m_bb = 0;
            exp_q.delete();
        end else if (m_owner == 0) begin
            if (m_valid && rdy) m_valid = 1'b0;
            if (ra && rb) m_owner = (m_last == 1) ? 2 : 1;
            else if (ra) m_owner = 1;
            else if (rb) m_owner = 2;
            m_run = 0;
        end else begin
            mine  = (m_owner == 1) ? ra : rb;
            other = (m_owner == 1) ? rb : ra;
            acc   = mine && (!m_valid || rdy);
            if (acc) begin
                exp_q.push_back((m_owner == 1) ? bus.din_a : bus.din_b);
                m_valid = 1'b1;
                m_run++;
                if (m_owner == 1) m_ba = (m_ba < 65535) ? m_ba + 1 : m_ba;
                else              m_bb = (m_bb < 65535) ? m_bb + 1 : m_bb;
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
            if (!mine) begin
                m_last  = m_owner;
                m_owner = other ? 3 - m_owner : 0;
                m_run   = 0;
            end else if (acc && (m_run % HOLD_MAX == 0) && other) begin
                m_last  = m_owner;
                m_owner = 3 - m_owner;
                m_run   = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: sample just after the falling edge, once this cycle's inputs are settled.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            #1;
            chk("gnt_a", 32'(bus.gnt_a), 32'(m_owner == 1));
            chk("gnt_b", 32'(bus.gnt_b), 32'(m_owner == 2));
            chk("gnt_overlap", 32'(bus.gnt_a & bus.gnt_b), 32'd0);
            chk("dout_valid", 32'(bus.dout_valid), 32'(m_valid));
`ifdef ARB_BEAT_CNT_EN
            chk("beats_a", 32'(beats_a), 32'(m_ba));
            chk("beats_b", 32'(beats_b), 32'(m_bb));
`endif
            if (bus.dout_valid === 1'b1 && bus.dout_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL scoreboard_empty: got beat %0h, expected no beat", bus.dout);
                end else begin
                    chk("dout", 32'(bus.dout), 32'(exp_q.pop_front()));
                end
                hs_src.push_back(bus.dout[7]);
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input logic r, input logic ra, input logic [7:0] da,
                       input logic rb, input logic [7:0] db, input logic rdy);
        @(negedge clk);
        rst            = r;
        bus.req_a      = ra;
        bus.din_a      = da;
        bus.req_b      = rb;
        bus.din_b      = db;
        bus.dout_ready = rdy;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        logic [11:0] pat;
        bit          rdy, stall_a, stall_b;
        bus.req_a = 1'b0; bus.din_a = '0;
        bus.req_b = 1'b0; bus.din_b = '0;
        bus.dout_ready = 1'b0;

        // Reset held two cycles with both requesting; A wins the first tie.
        cyc(1'b1, 1'b1, 8'h01, 1'b1, 8'h81, 1'b1);
        cyc(1'b1, 1'b1, 8'h01, 1'b1, 8'h81, 1'b1);
        cyc(1'b0, 1'b1, 8'h01, 1'b1, 8'h81, 1'b1);
        chk("rst_gnt_a", 32'(bus.gnt_a), 32'd0);
        chk("rst_gnt_b", 32'(bus.gnt_b), 32'd0);
        chk("rst_dout", 32'(bus.dout), 32'd0);
        chk("rst_valid", 32'(bus.dout_valid), 32'd0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("first_tie_gnt_a", 32'(bus.gnt_a), 32'd1);
        chk("first_tie_gnt_b", 32'(bus.gnt_b), 32'd0);

        // Single requester stream 11, 22, 33.
        do_reset();
        cyc(1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
        chk("single_gnt", 32'(bus.gnt_a), 32'd1);
        chk("single_not_yet_valid", 32'(bus.dout_valid), 32'd0);
        cyc(1'b0, 1'b1, 8'h22, 1'b0, 8'h00, 1'b1);
        chk("single_beat0", 32'({bus.dout_valid, bus.dout}), 32'h111);
        cyc(1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 1'b1);
        chk("single_beat1", 32'({bus.dout_valid, bus.dout}), 32'h122);
        cyc(1'b0, 1'b0, 8'h33, 1'b0, 8'h00, 1'b1);
        chk("single_beat2", 32'({bus.dout_valid, bus.dout}), 32'h133);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("single_release", 32'({bus.gnt_a, bus.dout_valid}), 32'd0);

        // Continuous contention: expect AAAABBBBAAAA with no bubble.
        do_reset();
        hs_src.delete();
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 8'(i), 1'b1, 8'(8'h80 + i), 1'b1);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("rr_beats_seen", 32'(hs_src.size() >= 12), 32'd1);
        if (hs_src.size() >= 12) begin
            pat = '0;
            for (int i = 0; i < 12; i++) pat = {pat[10:0], hs_src[i]};
            chk("rr_pattern", 32'(pat), 32'(12'b0000_1111_0000));
        end

        // Backpressure with B waiting: dout and grant frozen while stalled.
        do_reset();
        cyc(1'b0, 1'b1, 8'h5A, 1'b1, 8'hB0, 1'b0);
        cyc(1'b0, 1'b1, 8'h5A, 1'b1, 8'hB0, 1'b0);
        chk("bp_gnt", 32'(bus.gnt_a), 32'd1);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b1, 8'h5A, 1'b1, 8'hB0, 1'b0);
            chk("bp_hold", 32'({bus.gnt_a, bus.dout_valid, bus.dout}), 32'h35A);
        end
        cyc(1'b0, 1'b1, 8'h5B, 1'b1, 8'hB0, 1'b1);
        chk("bp_last_stall", 32'({bus.gnt_a, bus.dout_valid, bus.dout}), 32'h35A);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'hB0, 1'b1);
        chk("bp_resume", 32'({bus.gnt_a, bus.dout_valid, bus.dout}), 32'h35B);

        // Early release hands straight to B, then reset mid-burst.
        do_reset();
        cyc(1'b0, 1'b1, 8'h3A, 1'b1, 8'hC1, 1'b1);
        cyc(1'b0, 1'b1, 8'h3A, 1'b1, 8'hC1, 1'b1);
        cyc(1'b0, 1'b1, 8'h3B, 1'b1, 8'hC1, 1'b1);
        cyc(1'b0, 1'b0, 8'h3B, 1'b1, 8'hC1, 1'b1);
        chk("early_a_beat2", 32'({bus.gnt_a, bus.dout}), 32'h13B);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'hC1, 1'b1);
        chk("early_switch", 32'({bus.gnt_a, bus.gnt_b}), 32'd1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'hC2, 1'b1);
        chk("b_beat", 32'({bus.dout_valid, bus.dout}), 32'h1C1);
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 8'hC3, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("midburst_rst", 32'({bus.gnt_a, bus.gnt_b, bus.dout_valid, bus.dout}), 32'd0);

        // Randomized traffic; a stalled owner keeps req/din stable.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rdy     = ($urandom_range(0, 3) != 0);
            stall_a = (m_owner == 1) && m_valid && !rdy;
            stall_b = (m_owner == 2) && m_valid && !rdy;
            if (!stall_a) begin
                bus.req_a = ($urandom_range(0, 3) != 0);
                bus.din_a = {1'b0, 7'($urandom)};
            end
            if (!stall_b) begin
                bus.req_b = ($urandom_range(0, 2) != 0);
                bus.din_b = {1'b1, 7'($urandom)};
            end
            bus.dout_ready = rdy;
            rst = ($urandom_range(0, 255) == 0);
        end
        for (int n = 0; n < 4; n++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

`ifdef ARB_BEAT_CNT_EN
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'h0A, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'hB1, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'hB1, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("cnt_beats_a3", 32'(beats_a), 32'd3);
        chk("cnt_beats_b5", 32'(beats_b), 32'd5);
        do_reset();
        for (int i = 0; i < 70002; i++) cyc(1'b0, 1'b1, 8'(i), 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("cnt_saturate", 32'(beats_a), 32'h0000FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dual_req_rr_arbiter.md
Name: dual_req_rr_arbiter

Overview:
- Shares one registered output channel (dout/dout_valid) between two requesters, A and B.
- Arbitration is round-robin with a bounded burst length.
- Output side is a valid/ready handshake toward a single downstream sink.
- Sits in front of a shared capture/drive register so two independent sources can use it without conflict.

Parameters:
- DATA_W, 8, width of din_a, din_b and dout.
- HOLD_MAX, 4, maximum consecutive accepted beats per grant while the other requester is waiting. Legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- req_a  input  1  requester A has a beat on din_a.
- din_a  input  DATA_W  requester A data.
- req_b  input  1  requester B has a beat on din_b.
- din_b  input  DATA_W  requester B data.
- gnt_a  output  1  registered; A owns the channel.
- gnt_b  output  1  registered; B owns the channel.
- dout  output  DATA_W  registered output data.
- dout_valid  output  1  dout holds an unconsumed beat.
- dout_ready  input  1  sink accepts dout this cycle.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; gnt_a=gnt_b=0; dout=0; dout_valid=0; beat_cnt=0.
  - last_owner=B, so A wins the first tie.
  - Reset takes priority over every other event. A beat in flight is dropped and not replayed.
- States: IDLE, OWN_A, OWN_B. gnt_a=(state==OWN_A), gnt_b=(state==OWN_B). gnt_a and gnt_b are never both 1.
- load_en = !dout_valid || dout_ready (slot free or being drained this cycle).
- Beat accept: in OWN_X with req_X=1 and load_en=1:
  - dout<=din_X, dout_valid<=1 at that edge.
  - beat_cnt<=beat_cnt+1; the counter is 8-bit.
- Drain without reload: dout_valid=1 and dout_ready=1 with no accept → dout_valid<=0 and dout holds its value.
- IDLE transitions:
  - Both requesting: go to OWN of the requester that is not last_owner.
  - One requesting: go to that requester.
  - None requesting: stay in IDLE.
  - beat_cnt<=0 on entry to OWN_X.
- OWN_X transitions, evaluated each edge after the accept:
  - req_X=0: if the other requests, switch directly to OWN_other; else go to IDLE. last_owner<=X.
  - beat_cnt reaches HOLD_MAX (including the beat just accepted) and the other requests: switch to OWN_other, beat_cnt<=0, last_owner<=X.
  - beat_cnt reaches HOLD_MAX and the other is idle: stay in OWN_X, beat_cnt<=0 (no starvation risk).
  - Otherwise stay.
- Latency:
  - req sampled in IDLE → gnt high after 1 edge.
  - First beat accepted at the following edge; dout_valid visible 2 cycles after req.
  - With dout_ready held at 1: one beat per cycle while owned.
- Backpressure: dout_ready=0 with dout_valid=1 stalls accepts. The owner keeps its grant, beat_cnt does not advance, and the requester must hold req_X/din_X stable.
- A switch costs zero idle cycles: the new owner's gnt is high on the cycle after the old owner's last beat.
- A requester dropping req mid-burst is legal and ends its ownership as above.

Optional Feature:
- Macro ARB_BEAT_CNT_EN.
- Defined:
  - Adds outputs beats_a and beats_b, 16 bits each, registered.
  - Each increments on every accepted beat of its requester, saturates at 16'hFFFF, and clears on rst.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with req_a=req_b=1 → gnt_a=gnt_b=0, dout=0, dout_valid=0. Release → gnt_a=1 next cycle (A wins the first tie).
- Single requester: req_a=1, din_a=8'h11,8'h22,8'h33, dout_ready=1 → dout sequence 11,22,33 starting 2 cycles after req, dout_valid continuous, gnt_b=0 throughout.
- Contention, HOLD_MAX=4: req_a=req_b=1 continuously, dout_ready=1 → beat pattern AAAABBBBAAAA. gnt switches with no bubble and never overlaps.
- Backpressure: OWN_A with dout_valid=1, dout_ready=0 for 5 cycles, din_a=8'h5A held → dout, gnt_a and beat_cnt frozen. dout_ready=1 → next beat accepted on that edge.
- Early release and mid-burst reset:
  - req_a drops after 2 beats while req_b=1 → gnt_b=1 next cycle.
  - Assert rst during a B burst → all outputs cleared next edge, state IDLE.
- ARB_BEAT_CNT_EN defined: 3 A beats and 5 B beats → beats_a=3, beats_b=5. Force 70000 A beats → beats_a=16'hFFFF.
